risc_core_p: RTL and testbench

Parametrised multi-cycle RISC core. It is the next generation of the 16-bit processor top, with these changes:
- The control FSM and the execution datapath are merged into one block with configurable data width, address width and register count.
- It adds a variable-latency memory handshake (req/ack) in place of single-cycle memory.
- It adds a HALT state.

It sits between the board-level clock/reset conditioning and a single shared instruction/data memory port.

---
 rtl/risc_pkg.sv | 45 ++++
 rtl/risc_alu.sv | 47 ++++
 rtl/risc_core_p.sv | 231 +++++++++++++++++++++++
 tb/tb_risc_core_p.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: opcode constants, 4-bit FSM state encoding, JCC condition codes
// and status bit positions shared by risc_core_p and risc_alu.
package risc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_MEM_WR = 4'd4,
        ST_HALT   = 4'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JCC  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] CC_Z      = 2'd0;
    localparam logic [1:0] CC_N      = 2'd1;
    localparam logic [1:0] CC_C      = 2'd2;
    localparam logic [1:0] CC_ALWAYS = 2'd3;

    localparam int STAT_HALTED = 7;
    localparam int STAT_C      = 6;
    localparam int STAT_N      = 5;
    localparam int STAT_Z      = 4;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_SHR;
    endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu: combinational ALU for opcodes 0..9; carry is carry-out for
// ADD/INC, borrow for SUB/DEC, the shifted-out bit for shifts, else 0.
module risc_alu
    import risc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          n,
    output logic          z
);

    always_comb begin
        result = '0;
        c      = 1'b0;
        case (op)
            OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: {c, result} = {1'b0, a} - {1'b0, b};
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_INC: {c, result} = {1'b0, a} + (DW+1)'(1);
            OP_DEC: {c, result} = {1'b0, a} - (DW+1)'(1);
            OP_SHL: begin
                c      = a[DW-1];
                result = {a[DW-2:0], 1'b0};
            end
            OP_SHR: begin
                c      = a[0];
                result = {1'b0, a[DW-1:1]};
            end
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
    end

    assign n = result[DW-1];
    assign z = (result == '0);

endmodule

// File: rtl/risc_core_p.sv
// risc_core_p: parametrised multi-cycle RISC core on a shared req/ack memory
// port. Defining RISC_CORE_HALT_EN makes opcode F enter a terminal HALT state.
// state  | meaning
// FETCH  | read instruction at PC (first cycle after reset raises the request)
// DECODE | no memory access; choose next state
// EXEC   | ALU writeback or JMP, then fetch
// MEM_RD | read for LD / LDI / JCC
// MEM_WR | write for ST
// HALT   | frozen until reset
module risc_core_p
    import risc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int NREGS = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    input  logic          mem_ack,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] D_out,
    input  logic [DW-1:0] D_in,
    output logic [7:0]    status
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t        state, state_d;
    logic [AW-1:0] pc, pc_d, addr_d;
    logic [15:0]   ir, ir_d;
    logic [DW-1:0] rf [NREGS];
    logic          c_flag, n_flag, z_flag, c_d, n_d, z_d;
    logic          req_d, we_d;
    logic [DW-1:0] dout_d;
    logic          wr_en;
    logic [DW-1:0] wr_data;

    logic [3:0]    opcode;
    logic [RW-1:0] w_idx, r_idx, s_idx;
    logic [DW-1:0] r_val, s_val, alu_res;
    logic          alu_c, alu_n, alu_z, cc_true, halted;
    logic          unused_ir;

    assign opcode    = ir[15:12];
    assign w_idx     = ir[9 +: RW];
    assign r_idx     = ir[6 +: RW];
    assign s_idx     = ir[3 +: RW];
    assign r_val     = rf[r_idx];
    assign s_val     = rf[s_idx];
    assign unused_ir = ^ir;

    risc_alu #(.DW(DW)) u_alu (
        .op     (opcode),
        .a      (r_val),
        .b      (s_val),
        .result (alu_res),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z)
    );

    always_comb begin
        cc_true = 1'b1;
        case (ir[10:9])
            CC_Z:      cc_true = z_flag;
            CC_N:      cc_true = n_flag;
            CC_C:      cc_true = c_flag;
            CC_ALWAYS: cc_true = 1'b1;
        endcase
    end

`ifdef RISC_CORE_HALT_EN
    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        status              = '0;
        status[STAT_HALTED] = halted;
        status[STAT_C]      = c_flag;
        status[STAT_N]      = n_flag;
        status[STAT_Z]      = z_flag;
        status[3:0]         = state;
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;
        c_d     = c_flag;
        n_d     = n_flag;
        z_d     = z_flag;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = Address;
        dout_d  = D_out;
        wr_en   = 1'b0;
        wr_data = alu_res;
        case (state)
            ST_FETCH: begin
                if (!mem_req) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc;
                end else if (mem_ack) begin
                    ir_d    = D_in[15:0];
                    pc_d    = pc + AW'(1);
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LD: begin
                        state_d = ST_MEM_RD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = AW'(r_val);
                    end
                    OP_LDI, OP_JCC: begin
                        state_d = ST_MEM_RD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = pc;
                    end
                    OP_ST: begin
                        state_d = ST_MEM_WR;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = AW'(r_val);
                        dout_d  = s_val;
                    end
`ifdef RISC_CORE_HALT_EN
                    OP_HALT: state_d = ST_HALT;
`else
                    OP_HALT: state_d = ST_EXEC;
`endif
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (is_alu_op(opcode)) begin
                    wr_en   = 1'b1;
                    wr_data = alu_res;
                    c_d     = alu_c;
                    n_d     = alu_n;
                    z_d     = alu_z;
                end else if (opcode == OP_JMP) begin
                    pc_d = AW'(r_val);
                end
                state_d = ST_FETCH;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_d;
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    case (opcode)
                        OP_JCC: pc_d = cc_true ? AW'(D_in) : pc + AW'(1);
                        OP_LDI: begin
                            wr_en   = 1'b1;
                            wr_data = D_in;
                            pc_d    = pc + AW'(1);
                        end
                        default: begin
                            wr_en   = 1'b1;
                            wr_data = D_in;
                        end
                    endcase
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_d;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc;
                end
            end
`ifdef RISC_CORE_HALT_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Requests are registered so reset can drop them asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_FETCH;
            pc      <= '0;
            ir      <= '0;
            c_flag  <= 1'b0;
            n_flag  <= 1'b0;
            z_flag  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            Address <= '0;
            D_out   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            ir      <= ir_d;
            c_flag  <= c_d;
            n_flag  <= n_d;
            z_flag  <= z_d;
            mem_req <= req_d;
            mem_we  <= we_d;
            Address <= addr_d;
            D_out   <= dout_d;
            if (wr_en) begin
                rf[w_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_risc_core_p.sv
// tb_risc_core_p: directed programs against a wait-state memory model for risc_core_p.
module tb_risc_core_p;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [15:0] Address, D_out;
    logic [15:0] D_in = 16'h0;
    logic [7:0]  status;

    risc_core_p #(.DW(16), .AW(16), .NREGS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .mem_ack (mem_ack),
        .Address (Address),
        .D_out   (D_out),
        .D_in    (D_in),
        .status  (status)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [65536];
    int          checks = 0;
    int          failures = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          unstable = 0;
    logic [15:0] acc_q [$];
    int          acc_cyc_q [$];
    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q [$];
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr = 16'h0, p_dout = 16'h0;

    // memory model: ack after wait_n wait cycles of a held request
    always @(negedge clk) begin
        if (mem_ack) wcnt = 0;
        if (mem_req) begin
            if (wcnt >= wait_n) begin
                mem_ack = 1'b1;
                D_in    = mem[Address];
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            cyc = 0;
        end else begin
            cyc++;
            if (mem_req && p_req && !p_ack &&
                (Address !== p_addr || mem_we !== p_we || (mem_we && D_out !== p_dout)))
                unstable++;
            if (mem_req && mem_ack) begin
                acc_q.push_back(Address);
                acc_cyc_q.push_back(cyc);
                if (mem_we) begin
                    mem[Address] = D_out;
                    wr_addr_q.push_back(Address);
                    wr_data_q.push_back(D_out);
                    wr_cyc_q.push_back(cyc);
                end
            end
        end
        p_req  = mem_req;
        p_ack  = mem_ack;
        p_we   = mem_we;
        p_addr = Address;
        p_dout = D_out;
    end

    task automatic hold_rst(input int w);
        reset  = 1'b0;
        wait_n = w;
        acc_q.delete();
        acc_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        unstable = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        @(posedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_for(input bit writes, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((writes ? wr_data_q.size() : acc_q.size()) >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_ldi_add_st();
        mem[0] = 16'hC200; mem[1] = 16'hFFFF;   // LDI R1,FFFF
        mem[2] = 16'hC400; mem[3] = 16'h0001;   // LDI R2,1
        mem[4] = 16'hC800; mem[5] = 16'h0100;   // LDI R4,0100
        mem[6] = 16'h0650;                      // ADD R3,R1,R2
        mem[7] = 16'hB118;                      // ST [R4],R3
        mem[8] = 16'hD000;                      // JMP R0
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        checks++; if (Address !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", Address); end
        checks++; if (D_out !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", D_out); end
        checks++; if (status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", status); end
    endtask

    task automatic test_fetch_timing();
        bit ok;
        hold_rst(0);
        load_ldi_add_st();
        release_rst();
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL pre_edge_req got=%b exp=0", mem_req); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || Address !== 16'h0000 || mem_we !== 1'b0) begin
            failures++; $display("FAIL first_fetch got req=%b addr=%h we=%b exp req=1 addr=0000 we=0", mem_req, Address, mem_we); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0 || status[3:0] !== 4'd1) begin
            failures++; $display("FAIL decode_gap got req=%b state=%0d exp req=0 state=1", mem_req, status[3:0]); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || Address !== 16'h0001) begin
            failures++; $display("FAIL second_access got req=%b addr=%h exp req=1 addr=0001", mem_req, Address); end
        wait_for(1'b1, 1, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL zw_store_timeout got writes=%0d exp=1", wr_data_q.size());
        end else begin
            checks++; if (wr_addr_q[0] !== 16'h0100 || wr_data_q[0] !== 16'h0000) begin
                failures++; $display("FAIL add_wrap_store got addr=%h data=%h exp addr=0100 data=0000", wr_addr_q[0], wr_data_q[0]); end
            checks++; if (wr_cyc_q[0] !== 16) begin
                failures++; $display("FAIL zw_store_cycle got=%0d exp=16", wr_cyc_q[0]); end
            checks++; if (status[6:4] !== 3'b101) begin
                failures++; $display("FAIL add_flags got CNZ=%b exp=101", status[6:4]); end
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        hold_rst(3);
        load_ldi_add_st();
        release_rst();
        wait_for(1'b1, 1, 200, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL ws_store_timeout got writes=%0d exp=1", wr_data_q.size());
        end else begin
            checks++; if (wr_cyc_q[0] !== 43) begin
                failures++; $display("FAIL ws_store_cycle got=%0d exp=43", wr_cyc_q[0]); end
            checks++; if (acc_cyc_q[1] !== 10 || acc_q[1] !== 16'h0001) begin
                failures++; $display("FAIL ws_second_access got cyc=%0d addr=%h exp cyc=10 addr=0001", acc_cyc_q[1], acc_q[1]); end
            checks++; if (wr_addr_q[0] !== 16'h0100 || wr_data_q[0] !== 16'h0000) begin
                failures++; $display("FAIL ws_store got addr=%h data=%h exp addr=0100 data=0000", wr_addr_q[0], wr_data_q[0]); end
            checks++; if (unstable !== 0) begin
                failures++; $display("FAIL ws_stability got changes=%0d exp=0", unstable); end
        end
    endtask

    task automatic test_alu_mix();
        bit ok;
        hold_rst(0);
        mem[0]  = 16'hC800; mem[1] = 16'h0100;  // LDI R4,0100
        mem[2]  = 16'hC200; mem[3] = 16'h8001;  // LDI R1,8001
        mem[4]  = 16'h8440;                     // SHL R2,R1
        mem[5]  = 16'hB110;                     // ST [R4],R2
        mem[6]  = 16'h9640;                     // SHR R3,R1
        mem[7]  = 16'hB118;                     // ST [R4],R3
        mem[8]  = 16'h1A08;                     // SUB R5,R0,R1
        mem[9]  = 16'h4C68;                     // XOR R6,R1,R5
        mem[10] = 16'hB130;                     // ST [R4],R6
        mem[11] = 16'h7E00;                     // DEC R7,R0
        mem[12] = 16'hB138;                     // ST [R4],R7
        mem[13] = 16'hD000;                     // JMP R0
        release_rst();
        wait_for(1'b1, 4, 300, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL alu_timeout got writes=%0d exp=4", wr_data_q.size());
        end else begin
            checks++; if (wr_data_q[0] !== 16'h0002) begin failures++; $display("FAIL shl got=%h exp=0002", wr_data_q[0]); end
            checks++; if (wr_data_q[1] !== 16'h4000) begin failures++; $display("FAIL shr got=%h exp=4000", wr_data_q[1]); end
            checks++; if (wr_data_q[2] !== 16'hFFFE) begin failures++; $display("FAIL sub_xor got=%h exp=FFFE", wr_data_q[2]); end
            checks++; if (wr_data_q[3] !== 16'hFFFF) begin failures++; $display("FAIL dec got=%h exp=FFFF", wr_data_q[3]); end
            checks++; if (status[6:4] !== 3'b110) begin failures++; $display("FAIL dec_flags got CNZ=%b exp=110", status[6:4]); end
        end
    endtask

    task automatic test_reset_mid_store();
        hold_rst(3);
        mem[0] = 16'hB000;                      // ST [R0],R0
        release_rst();
        repeat (7) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            failures++; $display("FAIL st_pending got req=%b we=%b exp req=1 we=1", mem_req, mem_we); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL async_drop got req=%b we=%b exp req=0 we=0", mem_req, mem_we); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (wr_data_q.size() !== 0 || mem[0] !== 16'hB000) begin
            failures++; $display("FAIL abandoned_write got writes=%0d mem0=%h exp writes=0 mem0=B000", wr_data_q.size(), mem[0]); end
        wait_n = 0;
        release_rst();
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || Address !== 16'h0000) begin
            failures++; $display("FAIL refetch_zero got req=%b addr=%h exp req=1 addr=0000", mem_req, Address); end
    endtask

    task automatic test_jcc_wrap(input bit set_z, input logic [15:0] exp_next);
        bit ok;
        hold_rst(0);
        mem[0] = 16'hC200; mem[1] = 16'hFFFE;   // LDI R1,FFFE
        mem[2] = set_z ? 16'h1448 : 16'h6440;   // SUB R2,R1,R1 (Z=1) or INC R2,R1 (Z=0)
        mem[3] = 16'hD040;                      // JMP R1
        mem[16'hFFFE] = 16'hE000;               // JCC Z
        mem[16'hFFFF] = 16'h0200;
        mem[16'h0200] = 16'hD000;
        release_rst();
        wait_for(1'b0, 7, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL jcc_timeout got accesses=%0d exp=7", acc_q.size());
        end else begin
            checks++; if (acc_q[4] !== 16'hFFFE || acc_q[5] !== 16'hFFFF) begin
                failures++; $display("FAIL jcc_addr got %h,%h exp FFFE,FFFF", acc_q[4], acc_q[5]); end
            checks++; if (acc_q[6] !== exp_next) begin
                failures++; $display("FAIL jcc_next z=%0d got=%h exp=%h", set_z, acc_q[6], exp_next); end
        end
    endtask

    task automatic test_halt();
        hold_rst(0);
        mem[0] = 16'hF000;
        mem[1] = 16'hD000;
        release_rst();
`ifdef RISC_CORE_HALT_EN
        begin
            int req_seen = 0;
            repeat (3) @(posedge clk);
            #1;
            checks++; if (status !== 8'h85) begin failures++; $display("FAIL halt_status got=%h exp=85", status); end
            repeat (100) begin
                @(posedge clk); #1;
                if (mem_req) req_seen++;
            end
            checks++; if (req_seen !== 0) begin failures++; $display("FAIL halt_req got=%0d cycles exp=0", req_seen); end
            checks++; if (status !== 8'h85 || acc_q.size() !== 1) begin
                failures++; $display("FAIL halt_frozen got status=%h accesses=%0d exp status=85 accesses=1", status, acc_q.size()); end
        end
`else
        begin
            bit ok;
            wait_for(1'b0, 2, 50, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL nop_timeout got accesses=%0d exp=2", acc_q.size());
            end else begin
                checks++; if (acc_q[1] !== 16'h0001 || acc_cyc_q[1] !== 5) begin
                    failures++; $display("FAIL nop_continue got addr=%h cyc=%0d exp addr=0001 cyc=5", acc_q[1], acc_cyc_q[1]); end
                checks++; if (status[7] !== 1'b0) begin failures++; $display("FAIL nop_halted got=%b exp=0", status[7]); end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_timing();
        test_wait_states();
        test_alu_mix();
        test_reset_mid_store();
        test_jcc_wrap(1'b0, 16'h0000);
        test_jcc_wrap(1'b1, 16'h0200);
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
